// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: decode-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_pipe_reg_if;
  logic        stall_en;
  logic        flush;
  logic        freeze;
  logic        id_valid;
  logic [3:0]  id_opcode;
  logic [3:0]  id_srcReg1;
  logic [3:0]  id_srcReg2;
  logic [3:0]  id_dstReg;
  logic [15:0] id_rdata1;
  logic [15:0] id_rdata2;
  logic [15:0] id_imm;
  logic [4:0]  id_ctrl;
  logic        id_ex_valid;
  logic [3:0]  id_ex_opcode;
  logic [3:0]  id_ex_srcReg1;
  logic [3:0]  id_ex_srcReg2;
  logic [3:0]  id_ex_dstReg_out;
  logic [15:0] id_ex_rdata1;
  logic [15:0] id_ex_rdata2;
  logic [15:0] id_ex_imm;
  logic [4:0]  id_ex_ctrl;
  logic        halted;
  logic [15:0] bubble_cnt;
  modport master (
    output stall_en, flush, freeze, id_valid, id_opcode, id_srcReg1, id_srcReg2, id_dstReg,
           id_rdata1, id_rdata2, id_imm, id_ctrl,
    input  id_ex_valid, id_ex_opcode, id_ex_srcReg1, id_ex_srcReg2, id_ex_dstReg_out,
           id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_ctrl, halted, bubble_cnt
  );
  modport slave (
    input  stall_en, flush, freeze, id_valid, id_opcode, id_srcReg1, id_srcReg2, id_dstReg,
           id_rdata1, id_rdata2, id_imm, id_ctrl,
    output id_ex_valid, id_ex_opcode, id_ex_srcReg1, id_ex_srcReg2, id_ex_dstReg_out,
           id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_ctrl, halted, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with stall/flush bubbles, freeze, sticky halt and bubble counter
module id_ex_pipe_reg (
  input logic clk,
  input logic rst,
  id_ex_pipe_reg_if.slave bus
);
  logic hz;
  logic load;
  always_comb begin
    hz   = bus.stall_en | bus.flush;
    load = !bus.halted && !hz && bus.id_valid;
  end
  // every field is gated by load, so a bubble is all-zero and control never leaks without valid
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.id_ex_valid      <= 1'b0;
      bus.id_ex_opcode     <= '0;
      bus.id_ex_srcReg1    <= '0;
      bus.id_ex_srcReg2    <= '0;
      bus.id_ex_dstReg_out <= '0;
      bus.id_ex_rdata1     <= '0;
      bus.id_ex_rdata2     <= '0;
      bus.id_ex_imm        <= '0;
      bus.id_ex_ctrl       <= '0;
      bus.halted           <= 1'b0;
      bus.bubble_cnt       <= '0;
    end else if (!bus.freeze) begin
      bus.id_ex_valid      <= load;
      bus.id_ex_opcode     <= load ? bus.id_opcode  : '0;
      bus.id_ex_srcReg1    <= load ? bus.id_srcReg1 : '0;
      bus.id_ex_srcReg2    <= load ? bus.id_srcReg2 : '0;
      bus.id_ex_dstReg_out <= load ? bus.id_dstReg  : '0;
      bus.id_ex_rdata1     <= load ? bus.id_rdata1  : '0;
      bus.id_ex_rdata2     <= load ? bus.id_rdata2  : '0;
      bus.id_ex_imm        <= load ? bus.id_imm     : '0;
      bus.id_ex_ctrl       <= load ? bus.id_ctrl    : '0;
      bus.halted           <= bus.halted | (load & bus.id_ctrl[4]);
      bus.bubble_cnt       <= (!bus.halted && hz && bus.bubble_cnt != 16'hFFFF) ? bus.bubble_cnt + 16'd1 : bus.bubble_cnt;
    end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed stimulus with a queue-based scoreboard checked by an independent monitor
module tb_id_ex_pipe_reg;
  typedef struct packed {
    logic        v;
    logic [3:0]  op, s1, s2, d;
    logic [15:0] r1, r2, imm;
    logic [4:0]  ctrl;
  } in_t;
  typedef struct packed {
    in_t         f;
    logic        h;
    logic [15:0] c;
  } out_t;

  localparam in_t LW   = '{1'b1, 4'h8, 4'h1, 4'h0, 4'h3, 16'h1234, 16'h0000, 16'h0010, 5'h0B};
  localparam in_t ADD  = '{1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 16'h0005, 16'h0007, 16'h0000, 5'h04};
  localparam in_t SUB  = '{1'b1, 4'h2, 4'h5, 4'h6, 4'h7, 16'h00AA, 16'h0055, 16'h0000, 5'h04};
  localparam in_t HLT  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 5'h10};
  localparam in_t IDLE = '{1'b0, 4'h3, 4'h9, 4'h9, 4'h9, 16'hDEAD, 16'hBEEF, 16'h1111, 5'h1F};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  out_t  q[$];
  string tq[$];

  id_ex_pipe_reg_if bus();
  id_ex_pipe_reg dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic out_t cap(input in_t i, input logic h, input logic [15:0] c);
    return '{f: i, h: h, c: c};
  endfunction

  function automatic out_t bub(input logic h, input logic [15:0] c);
    return '{f: '0, h: h, c: c};
  endfunction

  task automatic drive(input logic st, input logic fl, input logic fz, input in_t i);
    bus.stall_en   = st;
    bus.flush      = fl;
    bus.freeze     = fz;
    bus.id_valid   = i.v;
    bus.id_opcode  = i.op;
    bus.id_srcReg1 = i.s1;
    bus.id_srcReg2 = i.s2;
    bus.id_dstReg  = i.d;
    bus.id_rdata1  = i.r1;
    bus.id_rdata2  = i.r2;
    bus.id_imm     = i.imm;
    bus.id_ctrl    = i.ctrl;
  endtask

  task automatic step(input logic st, input logic fl, input logic fz, input in_t i,
                      input bit chk, input out_t e, input string tag);
    @(negedge clk);
    drive(st, fl, fz, i);
    if (chk) begin
      q.push_back(e);
      tq.push_back(tag);
    end
    @(posedge clk);
  endtask

  // reset asserted mid-cycle while frozen and stalling; outputs must clear before the next edge
  task automatic rst_pulse(input string tag);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, IDLE);
    #2;
    q.push_back(bub(1'b0, 16'h0000));
    tq.push_back(tag);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, IDLE);
    rst = 1'b0;
  endtask

  initial forever begin
    out_t a, e;
    string t;
    @(posedge clk or posedge rst);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      t = tq.pop_front();
      a.f = '{bus.id_ex_valid, bus.id_ex_opcode, bus.id_ex_srcReg1, bus.id_ex_srcReg2, bus.id_ex_dstReg_out,
              bus.id_ex_rdata1, bus.id_ex_rdata2, bus.id_ex_imm, bus.id_ex_ctrl};
      a.h = bus.halted;
      a.c = bus.bubble_cnt;
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got v=%b op=%h s1=%h s2=%h d=%h r1=%h r2=%h imm=%h ctrl=%h halted=%b cnt=%h ; want v=%b op=%h s1=%h s2=%h d=%h r1=%h r2=%h imm=%h ctrl=%h halted=%b cnt=%h",
                 t, a.f.v, a.f.op, a.f.s1, a.f.s2, a.f.d, a.f.r1, a.f.r2, a.f.imm, a.f.ctrl, a.h, a.c,
                 e.f.v, e.f.op, e.f.s1, e.f.s2, e.f.d, e.f.r1, e.f.r2, e.f.imm, e.f.ctrl, e.h, e.c);
      end
    end
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, IDLE);
    step(0, 0, 0, LW, 1, bub(0, 16'd0), "reset_state");
    @(negedge clk) rst = 1'b0;
    step(0, 0, 0, LW,   1, cap(LW, 0, 16'd0),  "lw_capture");
    step(1, 0, 0, ADD,  1, bub(0, 16'd1),      "stall1");
    step(1, 0, 0, ADD,  1, bub(0, 16'd2),      "stall2");
    step(0, 0, 0, ADD,  1, cap(ADD, 0, 16'd2), "add_after_stall");
    step(1, 1, 0, SUB,  1, bub(0, 16'd3),      "stall_and_flush");
    step(0, 0, 0, SUB,  1, cap(SUB, 0, 16'd3), "sub_capture");
    step(1, 0, 1, ADD,  1, cap(SUB, 0, 16'd3), "freeze_stall");
    step(0, 1, 1, IDLE, 1, cap(SUB, 0, 16'd3), "freeze_flush");
    step(0, 0, 0, IDLE, 1, bub(0, 16'd3),      "invalid_no_count");
    step(0, 1, 0, LW,   1, bub(0, 16'd4),      "flush_valid");
    step(0, 1, 0, IDLE, 1, bub(0, 16'd5),      "flush_invalid");
    step(0, 0, 0, LW,   1, cap(LW, 0, 16'd5),  "lw_before_rst");
    rst_pulse("async_reset");
    step(0, 0, 0, HLT,  1, cap(HLT, 1, 16'd0), "halt_capture");
    step(0, 0, 0, ADD,  1, bub(1, 16'd0),      "halted_ignores_valid");
    step(0, 1, 0, ADD,  1, bub(1, 16'd0),      "halted_flush_no_count");
    step(1, 0, 1, LW,   1, bub(1, 16'd0),      "halted_freeze");
    step(0, 0, 0, LW,   1, bub(1, 16'd0),      "halt_sticky");
    rst_pulse("halt_reset");
    step(0, 0, 0, ADD,  1, cap(ADD, 0, 16'd0), "add_after_halt_reset");
    for (int k = 0; k < 32'hFFFD; k++) step(0, 1, 0, IDLE, 0, bub(0, 16'd0), "");
    step(0, 1, 0, IDLE, 1, bub(0, 16'hFFFE), "preload_fffe");
    step(0, 1, 0, IDLE, 1, bub(0, 16'hFFFF), "sat1");
    step(1, 1, 0, ADD,  1, bub(0, 16'hFFFF), "sat2");
    step(0, 1, 0, IDLE, 1, bub(0, 16'hFFFF), "sat3");
    step(0, 0, 0, SUB,  1, cap(SUB, 0, 16'hFFFF), "sub_at_sat");
    for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
